// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared FSM encodings, widths and register-match helper
package hazard_stall_ctrl_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        HSC_RUN      = 2'd0,
        HSC_MEM_WAIT = 2'd1,
        HSC_ERR_HOLD = 2'd2
    } hsc_state_e;

    // All 16 register IDs are compared; ARM has no hardwired zero register.
    function automatic logic src_match(
        input logic                  wb_en,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] src1,
        input logic [REG_ADDR_W-1:0] src2,
        input logic                  two_src
    );
        return wb_en && ((dst == src1) || (two_src && (dst == src2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / no-forwarding RAW stall and SRAM-wait freeze control
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  ID_valid,
    input  logic [REG_ADDR_W-1:0] ID_src1,
    input  logic [REG_ADDR_W-1:0] ID_src2,
    input  logic                  ID_two_src,
    input  logic                  EXE_wb_en,
    input  logic [REG_ADDR_W-1:0] EXE_dst,
    input  logic                  EXE_mem_read,
    input  logic                  MEM_wb_en,
    input  logic [REG_ADDR_W-1:0] MEM_dst,
    input  logic                  MEM_mem_req,
    input  logic                  sram_ready,
    output logic                  hazard,
    output logic                  freeze_all,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      hazard_cnt,
    output logic [CNT_W-1:0]      wait_cnt
);

    localparam int TIMER_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MEM_TIMEOUT);

    generate
        if (MEM_TIMEOUT < 1) begin : g_bad_timeout
            $error("hazard_stall_ctrl: MEM_TIMEOUT must be at least 1");
        end
    endgenerate

    hsc_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timeout_q, timeout_d;

    logic m_exe;
    logic m_mem;
    logic raw_stall;
    logic sram_wait;

    assign m_exe = src_match(EXE_wb_en, EXE_dst, ID_src1, ID_src2, ID_two_src);
    assign m_mem = src_match(MEM_wb_en, MEM_dst, ID_src1, ID_src2, ID_two_src);

    assign raw_stall = forward_en ? (ID_valid && m_exe && EXE_mem_read)
                                  : (ID_valid && (m_exe || m_mem));

    assign sram_wait = MEM_mem_req && !sram_ready;

    // Outputs are gated by rst so they read 0 for the whole reset interval.
    assign freeze_all = rst && sram_wait && (state_q != HSC_ERR_HOLD);
    assign hazard     = rst && raw_stall && !freeze_all;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        unique case (state_q)
            HSC_RUN: begin
                if (sram_wait) begin
                    state_d = HSC_MEM_WAIT;
                    timer_d = TIMER_W'(1);
                end
            end
            HSC_MEM_WAIT: begin
                // A dropped request (flush/abort) and a completed access both release the wait.
                if (!MEM_mem_req || sram_ready) begin
                    state_d = HSC_RUN;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_VAL) begin
                    state_d   = HSC_ERR_HOLD;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            HSC_ERR_HOLD: begin
                state_d = HSC_ERR_HOLD;
            end
            default: begin
                state_d = HSC_RUN;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HSC_RUN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hazard),
        .count (hazard_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_all),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int TO = 8;
    localparam int CW = 16;
    localparam int SW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en, ID_valid, ID_two_src;
    logic [3:0] ID_src1, ID_src2, EXE_dst, MEM_dst;
    logic       EXE_wb_en, EXE_mem_read, MEM_wb_en, MEM_mem_req, sram_ready;

    logic          hazard, freeze_all, mem_timeout;
    logic [CW-1:0] hazard_cnt, wait_cnt;
    logic          hazard_s, freeze_all_s, mem_timeout_s;
    logic [SW-1:0] hazard_cnt_s, wait_cnt_s;

    hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .ID_valid(ID_valid),
        .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
        .EXE_wb_en(EXE_wb_en), .EXE_dst(EXE_dst), .EXE_mem_read(EXE_mem_read),
        .MEM_wb_en(MEM_wb_en), .MEM_dst(MEM_dst), .MEM_mem_req(MEM_mem_req),
        .sram_ready(sram_ready), .hazard(hazard), .freeze_all(freeze_all),
        .mem_timeout(mem_timeout), .hazard_cnt(hazard_cnt), .wait_cnt(wait_cnt)
    );

    hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(SW)) dut_sat (
        .clk(clk), .rst(rst), .forward_en(forward_en), .ID_valid(ID_valid),
        .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
        .EXE_wb_en(EXE_wb_en), .EXE_dst(EXE_dst), .EXE_mem_read(EXE_mem_read),
        .MEM_wb_en(MEM_wb_en), .MEM_dst(MEM_dst), .MEM_mem_req(MEM_mem_req),
        .sram_ready(sram_ready), .hazard(hazard_s), .freeze_all(freeze_all_s),
        .mem_timeout(mem_timeout_s), .hazard_cnt(hazard_cnt_s), .wait_cnt(wait_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic          hz;
        logic          fz;
        logic          to;
        logic [CW-1:0] hc;
        logic [CW-1:0] wc;
        logic [SW-1:0] hcs;
        logic [SW-1:0] wcs;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [CW-1:0] m_hc, m_wc;
    logic [SW-1:0] m_hcs, m_wcs;

    task automatic cmp(input string tag, input string fld, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic clr_model();
        m_hc  = '0;
        m_wc  = '0;
        m_hcs = '0;
        m_wcs = '0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag, input logic hz, input logic fz, input logic to);
        exp_t e;
        e.tag = tag; e.hz = hz; e.fz = fz; e.to = to;
        e.hc = m_hc; e.wc = m_wc; e.hcs = m_hcs; e.wcs = m_wcs;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        cmp(e.tag, "hazard",        16'(hazard),        16'(e.hz));
        cmp(e.tag, "freeze_all",    16'(freeze_all),    16'(e.fz));
        cmp(e.tag, "mem_timeout",   16'(mem_timeout),   16'(e.to));
        cmp(e.tag, "hazard_cnt",    hazard_cnt,         e.hc);
        cmp(e.tag, "wait_cnt",      wait_cnt,           e.wc);
        cmp(e.tag, "hazard_s",      16'(hazard_s),      16'(e.hz));
        cmp(e.tag, "freeze_s",      16'(freeze_all_s),  16'(e.fz));
        cmp(e.tag, "timeout_s",     16'(mem_timeout_s), 16'(e.to));
        cmp(e.tag, "hazard_cnt_s",  16'(hazard_cnt_s),  16'(e.hcs));
        cmp(e.tag, "wait_cnt_s",    16'(wait_cnt_s),    16'(e.wcs));
        if (hz && m_hc  != '1) m_hc  = m_hc + 1'b1;
        if (hz && m_hcs != '1) m_hcs = m_hcs + 1'b1;
        if (fz && m_wc  != '1) m_wc  = m_wc + 1'b1;
        if (fz && m_wcs != '1) m_wcs = m_wcs + 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        forward_en = 1'b1; ID_valid = 1'b1; ID_two_src = 1'b0;
        ID_src1 = 4'd1; ID_src2 = 4'd2; EXE_dst = 4'd0; MEM_dst = 4'd0;
        EXE_wb_en = 1'b0; EXE_mem_read = 1'b0; MEM_wb_en = 1'b0;
        MEM_mem_req = 1'b0; sram_ready = 1'b1;
    endtask

    task automatic load_use(input logic [3:0] r);
        EXE_wb_en = 1'b1; EXE_mem_read = 1'b1; EXE_dst = r; ID_src1 = r;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        clr_model();
        load_use(4'd3);
        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step("reset", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        rst = 1'b1;
        step("idle", 1'b0, 1'b0, 1'b0);

        load_use(4'd3);
        step("load_use", 1'b1, 1'b0, 1'b0);
        idle_inputs();
        step("load_use_done", 1'b0, 1'b0, 1'b0);

        EXE_wb_en = 1'b1; EXE_dst = 4'd5; ID_src2 = 4'd5; ID_two_src = 1'b1;
        step("fwd_alu", 1'b0, 1'b0, 1'b0);
        forward_en = 1'b0;
        step("nofwd_alu", 1'b1, 1'b0, 1'b0);
        ID_two_src = 1'b0;
        step("nofwd_one_src", 1'b0, 1'b0, 1'b0);
        EXE_wb_en = 1'b0; MEM_wb_en = 1'b1; MEM_dst = 4'd1;
        step("nofwd_mem", 1'b1, 1'b0, 1'b0);
        forward_en = 1'b1;
        step("fwd_mem", 1'b0, 1'b0, 1'b0);
        idle_inputs();
        load_use(4'd0);
        step("r0_load_use", 1'b1, 1'b0, 1'b0);
        ID_valid = 1'b0;
        step("invalid_id", 1'b0, 1'b0, 1'b0);
        idle_inputs();

        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("sram_wait", 1'b0, 1'b1, 1'b0);
        sram_ready = 1'b1;
        step("sram_ready", 1'b0, 1'b0, 1'b0);
        sram_ready = 1'b0;
        for (int i = 0; i < 2; i++) step("b2b_wait", 1'b0, 1'b1, 1'b0);
        sram_ready = 1'b1;
        step("b2b_ready", 1'b0, 1'b0, 1'b0);
        MEM_mem_req = 1'b0;
        step("sram_idle", 1'b0, 1'b0, 1'b0);

        load_use(4'd3);
        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 0; i < 2; i++) step("lu_frozen", 1'b0, 1'b1, 1'b0);
        sram_ready = 1'b1;
        step("lu_unfrozen", 1'b1, 1'b0, 1'b0);
        idle_inputs();
        step("lu_clear", 1'b0, 1'b0, 1'b0);

        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("pre_abort", 1'b0, 1'b1, 1'b0);
        MEM_mem_req = 1'b0;
        step("abort", 1'b0, 1'b0, 1'b0);
        MEM_mem_req = 1'b1;
        for (int i = 0; i <= TO; i++) step("to_wait", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step("err_hold", 1'b0, 1'b0, 1'b1);
        load_use(4'd7);
        step("err_hold_lu", 1'b1, 1'b0, 1'b1);
        idle_inputs();
        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        step("err_sticky", 1'b0, 1'b0, 1'b1);

        rst = 1'b0;
        clr_model();
        step("rst_err", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        MEM_mem_req = 1'b0; sram_ready = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b0);

        MEM_mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("wait_pre_rst", 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        clr_model();
        step("async_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) step("wait_post_rst", 1'b0, 1'b1, 1'b0);
        sram_ready = 1'b1;
        step("ready_post_rst", 1'b0, 1'b0, 1'b0);
        MEM_mem_req = 1'b0;
        step("final", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
